sdram_inport_bist: RTL and testbench

- Self-contained initiator (master) for the SDRAM controller's inport request interface.
- On start, it performs two passes over a contiguous word range:
  - writes every word with full byte mask and a deterministic seed-derived pattern;
  - reads every word back and compares it against the regenerated pattern.
- Sits in front of sdram_axi_core for power-on memory test and in-system diagnostics.
- Reports pass/fail, error count and first failing address.

---
 rtl/sdram_inport_bist.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_inport_bist.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_inport_bist.sv
// sdram_inport_bist: built-in self test initiator for the SDRAM inport.
// Writes a seed-derived pattern over a word range, reads it back, compares,
// and reports pass/fail, a saturating error count and the first failing address.
module sdram_inport_bist #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic [31:0]      seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [31:0]      first_fail_addr_o,
    output logic [3:0]       inport_wr_o,
    output logic             inport_rd_o,
    output logic [31:0]      inport_addr_o,
    output logic [31:0]      inport_write_data_o,
    input  logic             inport_accept_i,
    input  logic             inport_ack_i,
    input  logic             inport_error_i,
    input  logic [31:0]      inport_read_data_i
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    // The first wait cycle after accept holds count 0, so the last allowed
    // wait cycle is ACK_TIMEOUT-1; no ack there abandons the access.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_ACK = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_ACK = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Test pattern for a word, from its address bits [17:2] and the seed.
    function automatic logic [31:0] pattern(input logic [15:0] word_idx,
                                            input logic [31:0] seed);
        return {word_idx, ~word_idx} ^ seed;
    endfunction

    state_t           state_r, next_state_s, hs_next_s, adv_state_s;
    logic [CNT_W-1:0] n_r, n_nxt_s, num_r, err_r, err_nxt_s;
    logic [31:0]      base_r, seed_r, addr_r, addr_nxt_s, ffa_r, ffa_nxt_s;
    logic [31:0]      seed_use_s, base_in_s, wdata_r;
    logic [TMO_W-1:0] tmo_r;
    logic [3:0]       wr_r;
    logic             rd_r, busy_r, done_r, pass_r;
    logic             start_go_s, complete_s, fail_s, wr_phase_s, last_s, err_inc_s;

    assign base_in_s  = base_addr_i & 32'hFFFF_FFFC;
    assign last_s     = (n_r == (num_r - CNT_W'(1)));
    assign seed_use_s = start_go_s ? seed_i : seed_r;
    assign err_inc_s  = complete_s & fail_s;

    // Handshake decoding, access completion/failure and next-state selection.
    always_comb begin
        hs_next_s   = state_r;
        start_go_s  = 1'b0;
        complete_s  = 1'b0;
        fail_s      = 1'b0;
        wr_phase_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    start_go_s = 1'b1;
                    hs_next_s  = (num_words_i == {CNT_W{1'b0}}) ? ST_DONE : ST_WR_REQ;
                end else begin
                    hs_next_s = ST_IDLE;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                wr_phase_s = (state_r == ST_WR_REQ);
                if (inport_accept_i) begin
                    if (inport_ack_i) begin
                        complete_s = 1'b1;
                        fail_s     = inport_error_i |
                                     (~wr_phase_s & (inport_read_data_i != pattern(addr_r[17:2], seed_r)));
                    end else begin
                        hs_next_s = wr_phase_s ? ST_WR_ACK : ST_RD_ACK;
                    end
                end else begin
                    hs_next_s = state_r;
                end
            end
            ST_WR_ACK, ST_RD_ACK: begin
                wr_phase_s = (state_r == ST_WR_ACK);
                if (inport_ack_i) begin
                    complete_s = 1'b1;
                    fail_s     = inport_error_i |
                                 (~wr_phase_s & (inport_read_data_i != pattern(addr_r[17:2], seed_r)));
                end else if (tmo_r == TMO_LAST) begin
                    complete_s = 1'b1;
                    fail_s     = 1'b1;
                end else begin
                    hs_next_s = state_r;
                end
            end
            ST_DONE: hs_next_s = ST_IDLE;
            default: hs_next_s = ST_IDLE;
        endcase

        if (last_s) begin
            adv_state_s = wr_phase_s ? ST_RD_REQ : ST_DONE;
        end else begin
            adv_state_s = wr_phase_s ? ST_WR_REQ : ST_RD_REQ;
        end
        next_state_s = complete_s ? adv_state_s : hs_next_s;
    end

    // Word index, address, error count and first-fail address updates.
    always_comb begin
        n_nxt_s    = n_r;
        addr_nxt_s = addr_r;
        err_nxt_s  = err_r;
        ffa_nxt_s  = ffa_r;
        if (start_go_s) begin
            n_nxt_s    = {CNT_W{1'b0}};
            addr_nxt_s = base_in_s;
            err_nxt_s  = {CNT_W{1'b0}};
            ffa_nxt_s  = 32'h0000_0000;
        end else if (complete_s) begin
            n_nxt_s    = last_s ? {CNT_W{1'b0}} : (n_r + CNT_W'(1));
            addr_nxt_s = last_s ? base_r : (addr_r + 32'd4);
            if (err_inc_s) begin
                err_nxt_s = (&err_r) ? err_r : (err_r + CNT_W'(1));
                ffa_nxt_s = (err_r == {CNT_W{1'b0}}) ? addr_r : ffa_r;
            end else begin
                err_nxt_s = err_r;
                ffa_nxt_s = ffa_r;
            end
        end else begin
            n_nxt_s    = n_r;
            addr_nxt_s = addr_r;
        end
    end

    // State, datapath and registered request/status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            n_r     <= {CNT_W{1'b0}};
            num_r   <= {CNT_W{1'b0}};
            err_r   <= {CNT_W{1'b0}};
            base_r  <= 32'h0000_0000;
            seed_r  <= 32'h0000_0000;
            addr_r  <= 32'h0000_0000;
            ffa_r   <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            tmo_r   <= {TMO_W{1'b0}};
            wr_r    <= 4'h0;
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            n_r     <= n_nxt_s;
            addr_r  <= addr_nxt_s;
            err_r   <= err_nxt_s;
            ffa_r   <= ffa_nxt_s;
            if (start_go_s) begin
                base_r <= base_in_s;
                seed_r <= seed_i;
                num_r  <= num_words_i;
            end else begin
                base_r <= base_r;
                seed_r <= seed_r;
                num_r  <= num_r;
            end
            if (state_r == ST_WR_ACK || state_r == ST_RD_ACK) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end else begin
                tmo_r <= {TMO_W{1'b0}};
            end
            wr_r    <= (next_state_s == ST_WR_REQ) ? 4'hF : 4'h0;
            rd_r    <= (next_state_s == ST_RD_REQ);
            wdata_r <= (next_state_s == ST_WR_REQ) ? pattern(addr_nxt_s[17:2], seed_use_s) : wdata_r;
            busy_r  <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
            done_r  <= (next_state_s == ST_DONE);
            if (next_state_s == ST_DONE) begin
                pass_r <= (err_nxt_s == {CNT_W{1'b0}});
            end else if (start_go_s) begin
                pass_r <= 1'b0;
            end else begin
                pass_r <= pass_r;
            end
        end
    end

    assign busy_o              = busy_r;
    assign done_o              = done_r;
    assign pass_o              = pass_r;
    assign err_count_o         = err_r;
    assign first_fail_addr_o   = ffa_r;
    assign inport_wr_o         = wr_r;
    assign inport_rd_o         = rd_r;
    assign inport_addr_o       = addr_r;
    assign inport_write_data_o = wdata_r;
endmodule

// File: tb/tb_sdram_inport_bist.sv
// Self-checking bench for sdram_inport_bist: table of test runs against a
// behavioural responder/memory and a reference model of expected accesses.
module tb_sdram_inport_bist;
    localparam int CNT_W  = 16;
    localparam int ACK_TO = 8;

    logic             clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic [31:0]      base_addr_i = 32'h0, seed_i = 32'h0;
    logic [CNT_W-1:0] num_words_i = '0;
    logic             busy_o, done_o, pass_o, inport_rd_o;
    logic [CNT_W-1:0] err_count_o;
    logic [31:0]      first_fail_addr_o, inport_addr_o, inport_write_data_o;
    logic [3:0]       inport_wr_o;
    logic             inport_accept_i = 1'b0, inport_ack_i = 1'b0, inport_error_i = 1'b0;
    logic [31:0]      inport_read_data_i = 32'h0;

    sdram_inport_bist #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_words_i(num_words_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_count_o(err_count_o), .first_fail_addr_o(first_fail_addr_o),
        .inport_wr_o(inport_wr_o), .inport_rd_o(inport_rd_o), .inport_addr_o(inport_addr_o),
        .inport_write_data_o(inport_write_data_o), .inport_accept_i(inport_accept_i),
        .inport_ack_i(inport_ack_i), .inport_error_i(inport_error_i),
        .inport_read_data_i(inport_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] base; int num; logic [31:0] seed; int acc_dly; int ack_lat;
        bit flip_en; logic [31:0] flip_addr; bit err_en; logic [31:0] err_addr;
        bit noack_en; logic [31:0] noack_addr;
        bit exp_pass; int exp_err; logic [31:0] exp_ffa;
    } vec_t;
    typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; } req_t;

    vec_t        vecs [12];
    vec_t        cfg;
    req_t        exp_q [$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wlog [$];
    int          tests = 0, fails = 0;
    int          cyc = 0, req_cnt = 0, pend_cnt = 0, wait_cnt = 0, to_mark = 0;
    bit          seen = 0, pend = 0, stable = 0, to_armed = 0, hold_rd = 0, pend_wr = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [68:0] snap = '0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
        return {a[17:2], ~a[17:2]} ^ s;
    endfunction

    // Reference model: expected error count / first failing address of a run.
    function automatic vec_t model(input vec_t v);
        logic [31:0] b, a;
        bit f;
        b = v.base & 32'hFFFF_FFFC;
        v.exp_err = 0;
        v.exp_ffa = 32'h0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < v.num; k++) begin
                a = b + 32'(4 * k);
                f = (v.err_en && a == v.err_addr) ||
                    (p == 0 ? (v.noack_en && a == v.noack_addr) : (v.flip_en && a == v.flip_addr));
                if (f) begin
                    if (v.exp_err == 0) v.exp_ffa = a;
                    v.exp_err++;
                end
            end
        end
        v.exp_pass = (v.exp_err == 0);
        return v;
    endfunction

    task automatic build_queue(input vec_t v);
        logic [31:0] a;
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < v.num; k++) begin
                a = (v.base & 32'hFFFF_FFFC) + 32'(4 * k);
                exp_q.push_back('{p == 0, a, (p == 0) ? pat(a, v.seed) : 32'h0});
            end
        end
    endtask

    task automatic drive_ack(input bit is_wr, input logic [31:0] a);
        logic [31:0] d;
        inport_ack_i   = 1'b1;
        inport_error_i = cfg.err_en && (a == cfg.err_addr);
        if (!is_wr) begin
            d = mem.exists(a) ? mem[a] : 32'h0;
            if (cfg.flip_en && a == cfg.flip_addr) d = d ^ 32'h1;
            inport_read_data_i = d;
        end
    endtask

    // Responder: memory-backed controller with configurable accept/ack timing.
    always @(negedge clk_i) begin
        logic [68:0] cur;
        req_t e;
        int lat;
        cur = {inport_wr_o, inport_rd_o, inport_addr_o, inport_write_data_o};
        inport_accept_i = 1'b0; inport_ack_i = 1'b0; inport_error_i = 1'b0;
        inport_read_data_i = 32'h0;
        cyc++;
        if (rst_i) begin
            seen = 0; pend = 0; to_armed = 0;
        end else if (pend) begin
            chk32("one_outstanding", 32'({inport_wr_o, inport_rd_o}), 32'h0);
            if (pend_cnt == 0) begin
                drive_ack(pend_wr, pend_addr);
                pend = 0;
            end else pend_cnt--;
        end else if (inport_wr_o != 4'h0 || inport_rd_o) begin
            if (!seen) begin
                seen = 1; snap = cur; stable = 1; wait_cnt = 0;
                if (to_armed) begin
                    to_armed = 0;
                    chk_rng("timeout_gap", cyc - to_mark, ACK_TO, ACK_TO + 2);
                end
            end else if (cur !== snap) stable = 0;
            if (wait_cnt >= cfg.acc_dly && !(hold_rd && inport_rd_o)) begin
                inport_accept_i = 1'b1;
                seen = 0;
                req_cnt++;
                chk32("req_stable", 32'(stable), 32'h1);
                if (exp_q.size() == 0) chk32("extra_req", inport_addr_o, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk32("req_kind", 32'({inport_wr_o, inport_rd_o}), e.is_wr ? 32'h1E : 32'h01);
                    chk32("req_addr", inport_addr_o, e.addr);
                    if (e.is_wr) chk32("req_wdata", inport_write_data_o, e.data);
                end
                if (inport_wr_o != 4'h0) begin
                    mem[inport_addr_o] = inport_write_data_o;
                    wlog.push_back(inport_write_data_o);
                end
                if (cfg.noack_en && inport_wr_o != 4'h0 && inport_addr_o == cfg.noack_addr) begin
                    to_armed = 1; to_mark = cyc;
                end else begin
                    lat = $urandom_range(cfg.ack_lat, 0);
                    if (lat == 0) drive_ack(inport_wr_o != 4'h0, inport_addr_o);
                    else begin
                        pend = 1; pend_cnt = lat - 1;
                        pend_wr = (inport_wr_o != 4'h0); pend_addr = inport_addr_o;
                    end
                end
            end else wait_cnt++;
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int cycles;
        bit got_done;
        cfg = v;
        build_queue(v);
        mem.delete();
        wlog.delete();
        @(negedge clk_i);
        base_addr_i = v.base; num_words_i = CNT_W'(v.num); seed_i = v.seed; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; base_addr_i = 32'hDEAD_0000; num_words_i = CNT_W'(7); seed_i = 32'h1111_2222;
        cycles = 0;
        while (!done_o && cycles < 2000) begin
            start_i = (cycles == 3) && busy_o;
            @(negedge clk_i);
            cycles++;
        end
        start_i = 1'b0;
        got_done = done_o;
        chk32({tag, "_done"}, 32'(got_done), 32'h1);
        chk32({tag, "_busy_at_done"}, 32'(busy_o), 32'h0);
        chk32({tag, "_pass"}, 32'(pass_o), 32'(v.exp_pass));
        chk32({tag, "_err_count"}, 32'(err_count_o), 32'(v.exp_err));
        chk32({tag, "_first_fail"}, first_fail_addr_o, v.exp_ffa);
        chk32({tag, "_all_reqs"}, 32'(exp_q.size()), 32'h0);
        @(negedge clk_i);
        chk32({tag, "_done_pulse"}, 32'(done_o), 32'h0);
        chk32({tag, "_pass_hold"}, 32'(pass_o), 32'(v.exp_pass));
    endtask

    initial begin
        vec_t v;
        int cycles, rc;
        bit got;
        vecs[0] = '{32'h0, 3, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 32'h0};
        vecs[1] = '{32'h100, 4, 32'hA5A5A5A5, 0, 2, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 32'h108};
        vecs[2] = '{32'h200, 3, 32'h1234, 5, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 32'h0};
        vecs[3] = '{32'h0, 2, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 1, 32'h4};
        vecs[4] = '{32'h103, 2, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 2, 32'h104};
        vecs[5] = '{32'hFFFFFFF8, 4, 32'h5A5A0000, 1, 3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 32'h0};
        for (int i = 6; i < 12; i++) begin
            v = '{$urandom, $urandom_range(6, 1), $urandom, $urandom_range(3, 0), $urandom_range(3, 0),
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0};
            rc = $urandom_range(3, 0);
            v.flip_en = (rc == 1); v.err_en = (rc == 2); v.noack_en = (rc == 3);
            v.flip_addr  = (v.base & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(v.num - 1, 0));
            v.err_addr   = v.flip_addr;
            v.noack_addr = v.flip_addr;
            vecs[i] = model(v);
        end
        cfg = vecs[0];

        #12;
        chk32("reset_outputs", 32'({busy_o, done_o, pass_o, err_count_o, inport_wr_o, inport_rd_o}), 32'h0);
        chk32("reset_addr_data", inport_addr_o | inport_write_data_o | first_fail_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                chk32("wr_pat0", (wlog.size() > 0) ? wlog[0] : 32'hX, 32'h0000FFFF);
                chk32("wr_pat1", (wlog.size() > 1) ? wlog[1] : 32'hX, 32'h0001FFFE);
                chk32("wr_pat2", (wlog.size() > 2) ? wlog[2] : 32'hX, 32'h0002FFFD);
            end
        end

        // num=0: done within two cycles, no requests
        rc = req_cnt;
        @(negedge clk_i);
        num_words_i = CNT_W'(0); base_addr_i = 32'h40; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cycles = 1;
        while (!done_o && cycles < 6) begin
            @(negedge clk_i);
            cycles++;
        end
        got = done_o;
        chk32("zero_done", 32'(got), 32'h1);
        chk_rng("zero_latency", cycles, 1, 2);
        chk32("zero_pass", 32'(pass_o), 32'h1);
        chk32("zero_no_reqs", 32'(req_cnt - rc), 32'h0);

        // reset in the middle of RD_REQ, then a clean run
        v = '{32'h40, 2, 32'h77, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 32'h0};
        cfg = v; build_queue(v); mem.delete(); hold_rd = 1;
        @(negedge clk_i);
        base_addr_i = v.base; num_words_i = CNT_W'(v.num); seed_i = v.seed; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cycles = 0;
        while (!inport_rd_o && cycles < 200) begin
            @(negedge clk_i);
            cycles++;
        end
        chk32("rst_reached_rd", 32'(inport_rd_o), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk32("rst_mid_ctrl", 32'({busy_o, done_o, pass_o, err_count_o, inport_wr_o, inport_rd_o}), 32'h0);
        chk32("rst_mid_addr", inport_addr_o | inport_write_data_o | first_fail_addr_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0; hold_rd = 0;
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
